// File: rtl/jt49_exp_seq_if.sv
// Bundle of the level-snapshot request and amplitude results for jt49_exp_seq.
// The master drives the conversion request; the slave (the converter) returns results.
interface jt49_exp_seq_if #(
    parameter int unsigned CH = 3,
    parameter int unsigned DW = 10
);
    localparam int unsigned MW = DW + $clog2(CH + 1);

    logic              start;
    logic [1:0]        comp;
    logic [CH-1:0]     mute;
    logic [5*CH-1:0]   din;
    logic              busy;
    logic              valid;
    logic [DW*CH-1:0]  dout;
    logic [MW-1:0]     mix;

    modport master (output start, comp, mute, din, input busy, valid, dout, mix);
    modport slave  (input start, comp, mute, din, output busy, valid, dout, mix);
endinterface

// File: rtl/jt49_exp_seq.sv
// Time-multiplexed volume-to-amplitude converter: one channel per cycle through a
// piece-wise-linear exponential curve with compression, mute and an accumulated mix.
module jt49_exp_seq #(
    parameter int unsigned CH = 3,
    parameter int unsigned DW = 10
) (
    input  logic           clk,
    input  logic           rst,
    jt49_exp_seq_if.slave  bus
);
    localparam int unsigned MW = DW + $clog2(CH + 1);
    localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [9:0]  FULL = 10'd896;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [4:0]      lvl_q [CH];
    logic [1:0]      comp_q;
    logic [CH-1:0]   mute_q;
    logic            s1_vld_q;
    logic [IW-1:0]   s1_idx_q;
    logic [9:0]      s1_c_q;
    logic [9:0]      s1_c_d;
    logic [DW-1:0]   dout_q [CH];
    logic [MW-1:0]   acc_q;
    logic [MW-1:0]   mix_q;
    logic            busy_q;
    logic            valid_q;

    logic [4:0]      lvl;
    logic [9:0]      base;
    logic [DW-1:0]   amp;
    logic            accept_c;
    logic [DW*CH-1:0] dout_flat;

    // A request is taken from IDLE, or on the draining DONE cycle for back-to-back runs
    always_comb begin
        accept_c = bus.start &&
                   ((state_q == IDLE) || ((state_q == DONE) && !s1_vld_q));
    end

    // Stage-1 curve: mantissa 4+m shifted by exponent, then offset-compressed toward full scale
    always_comb begin
        lvl    = lvl_q[idx_q];
        base   = 10'({1'b1, lvl[1:0]}) << lvl[4:2];
        s1_c_d = '0;
        if (lvl != 5'd0 && !mute_q[idx_q])
            s1_c_d = (base >> comp_q) + (FULL - (FULL >> comp_q));
        amp    = DW'(s1_c_q) << (DW - 10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            comp_q   <= '0;
            mute_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_c_q   <= '0;
            acc_q    <= '0;
            mix_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                lvl_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            valid_q  <= 1'b0;
            s1_vld_q <= 1'b0;

            // Stage 2: publish the channel amplitude and accumulate the mix
            if (s1_vld_q) begin
                dout_q[s1_idx_q] <= amp;
                acc_q            <= acc_q + MW'(amp);
            end

            if (accept_c) begin
                for (int i = 0; i < CH; i++) lvl_q[i] <= bus.din[5*i +: 5];
                comp_q <= bus.comp;
                mute_q <= bus.mute;
                acc_q  <= '0;
                idx_q  <= '0;
            end

            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (accept_c) state_q <= CONV;
                end
                CONV: begin
                    busy_q   <= 1'b1;
                    s1_vld_q <= 1'b1;
                    s1_idx_q <= idx_q;
                    s1_c_q   <= s1_c_d;
                    idx_q    <= idx_q + IW'(1);
                    if (idx_q == IW'(CH - 1)) state_q <= DONE;
                end
                DONE: begin
                    if (s1_vld_q) begin
                        busy_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b1;
                        mix_q   <= acc_q;
                        busy_q  <= 1'b0;
                        state_q <= accept_c ? CONV : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        dout_flat = '0;
        for (int i = 0; i < CH; i++) dout_flat[DW*i +: DW] = dout_q[i];
    end

    assign bus.dout  = dout_flat;
    assign bus.mix   = mix_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
endmodule
